// File: rtl/hc595_chain_driver.sv
`default_nettype none
// ============================================================================
// Module   : hc595_chain_driver
// Purpose  : Serial driver for a chain of cascaded 74HC595 shift registers.
//            Takes a DATA_W-bit word through a start/ready handshake, shifts
//            it out on ds/sh_clk at a programmable rate, then pulses st_clk
//            to latch the 595 outputs and pulses done. While auto_en is held
//            high, a new frame is started automatically whenever idle.
// Ports    : clk_50mhz - system clock (only clock in the block)
//            rst       - synchronous, active-high reset
//            start     - request one frame (sampled only while ready=1)
//            auto_en   - level; free-running refresh while high
//            data      - parallel word, captured on the accept cycle only
//            ready     - high in IDLE
//            done      - single-cycle pulse when the frame has been latched
//            ds        - serial data to the first 595 in the chain
//            sh_clk    - shift clock (595 samples ds on the rising edge)
//            st_clk    - storage clock (rising edge updates the 595 outputs)
// Revision : 1.0 - initial parametrised release
// ============================================================================
module hc595_chain_driver #(
   parameter int DATA_W    = 16,
   parameter int CLK_DIV   = 2,
   parameter bit MSB_FIRST = 1'b1
) (
   input  logic              clk_50mhz,
   input  logic              rst,
   input  logic              start,
   input  logic              auto_en,
   input  logic [DATA_W-1:0] data,
   output logic              ready,
   output logic              done,
   output logic              ds,
   output logic              sh_clk,
   output logic              st_clk
);

   localparam int c_BIT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
   localparam int c_DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

   localparam logic [c_BIT_W-1:0] c_LAST_BIT = c_BIT_W'(DATA_W - 1);
   localparam logic [c_DIV_W-1:0] c_LAST_DIV = c_DIV_W'(CLK_DIV - 1);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_SHIFT = 2'd1,
      S_LATCH = 2'd2
   } state_t;

   // Registered state
   state_t              r_state;
   logic [c_DIV_W-1:0]  r_div_cnt;
   logic [c_BIT_W-1:0]  r_bit_cnt;
   logic                r_phase;
   logic [DATA_W-1:0]   r_shreg;
   logic                r_ds;
   logic                r_sh_clk;
   logic                r_st_clk;
   logic                r_done;
   logic                r_ready;

   // Next-state values
   state_t              w_state;
   logic [c_DIV_W-1:0]  w_div_cnt;
   logic [c_BIT_W-1:0]  w_bit_cnt;
   logic                w_phase;
   logic [DATA_W-1:0]   w_shreg;
   logic                w_ds;
   logic                w_sh_clk;
   logic                w_st_clk;
   logic                w_done;
   logic                w_ready;

   logic                w_tick;
   logic                w_first_bit;
   logic                w_next_bit;
   logic [DATA_W-1:0]   w_shreg_shifted;

   // Bit order only changes which end of the shift register feeds ds.
   generate
      if (MSB_FIRST) begin : g_msb_first
         assign w_first_bit     = data[DATA_W-1];
         assign w_shreg_shifted = r_shreg << 1;
         assign w_next_bit      = w_shreg_shifted[DATA_W-1];
      end else begin : g_lsb_first
         assign w_first_bit     = data[0];
         assign w_shreg_shifted = r_shreg >> 1;
         assign w_next_bit      = w_shreg_shifted[0];
      end
   endgenerate

   assign w_tick = (r_div_cnt == c_LAST_DIV);

   always_comb begin
      w_state   = r_state;
      w_div_cnt = r_div_cnt;
      w_bit_cnt = r_bit_cnt;
      w_phase   = r_phase;
      w_shreg   = r_shreg;
      w_ds      = r_ds;
      w_sh_clk  = r_sh_clk;
      w_st_clk  = r_st_clk;
      w_done    = 1'b0;
      w_ready   = r_ready;

      case (r_state)
         S_IDLE: begin
            w_div_cnt = '0;
            if (start | auto_en) begin
               w_shreg   = data;
               w_ds      = w_first_bit;
               w_sh_clk  = 1'b0;
               w_bit_cnt = '0;
               w_phase   = 1'b0;
               w_ready   = 1'b0;
               w_state   = S_SHIFT;
            end
         end

         S_SHIFT: begin
            if (w_tick) begin
               w_div_cnt = '0;
               if (!r_phase) begin
                  w_sh_clk = 1'b1;
                  w_phase  = 1'b1;
               end else begin
                  // ds only moves on the falling edge of sh_clk, giving a
                  // full half-period of setup and hold around each rise.
                  w_sh_clk = 1'b0;
                  if (r_bit_cnt == c_LAST_BIT) begin
                     w_st_clk = 1'b1;
                     w_state  = S_LATCH;
                  end else begin
                     w_bit_cnt = r_bit_cnt + 1'b1;
                     w_shreg   = w_shreg_shifted;
                     w_ds      = w_next_bit;
                     w_phase   = 1'b0;
                  end
               end
            end else begin
               w_div_cnt = r_div_cnt + 1'b1;
            end
         end

         S_LATCH: begin
            if (w_tick) begin
               w_div_cnt = '0;
               w_st_clk  = 1'b0;
               w_done    = 1'b1;
               w_ready   = 1'b1;
               w_state   = S_IDLE;
            end else begin
               w_div_cnt = r_div_cnt + 1'b1;
            end
         end

         default: begin
            // Unreachable encoding: fall back to a clean idle.
            w_state   = S_IDLE;
            w_div_cnt = '0;
            w_sh_clk  = 1'b0;
            w_st_clk  = 1'b0;
            w_ready   = 1'b1;
         end
      endcase
   end

   always_ff @(posedge clk_50mhz) begin
      if (rst) begin
         r_state   <= S_IDLE;
         r_div_cnt <= '0;
         r_bit_cnt <= '0;
         r_phase   <= 1'b0;
         r_shreg   <= '0;
         r_ds      <= 1'b0;
         r_sh_clk  <= 1'b0;
         r_st_clk  <= 1'b0;
         r_done    <= 1'b0;
         r_ready   <= 1'b1;
      end else begin
         r_state   <= w_state;
         r_div_cnt <= w_div_cnt;
         r_bit_cnt <= w_bit_cnt;
         r_phase   <= w_phase;
         r_shreg   <= w_shreg;
         r_ds      <= w_ds;
         r_sh_clk  <= w_sh_clk;
         r_st_clk  <= w_st_clk;
         r_done    <= w_done;
         r_ready   <= w_ready;
      end
   end

   assign ready  = r_ready;
   assign done   = r_done;
   assign ds     = r_ds;
   assign sh_clk = r_sh_clk;
   assign st_clk = r_st_clk;

endmodule
`default_nettype wire

// File: tb/tb_hc595_chain_driver.sv
`default_nettype none
// ============================================================================
// Module   : tb_hc595_chain_driver
// Purpose  : Self-checking bench for hc595_chain_driver. Four instances cover
//            16b/div2/MSB, 16b/div2/LSB, 24b/div1/MSB and 8b/div3/MSB.
//            Every output of every instance is compared each cycle against a
//            reference model that derives the waveform from the number of
//            cycles elapsed since the accepting edge.
// Revision : 1.0 - initial release
// ============================================================================
module tb_hc595_chain_driver;

   logic        clk;
   logic        rst;
   logic [3:0]  st;
   logic [3:0]  au;
   logic [23:0] dat [4];
   wire  [3:0]  rdy;
   wire  [3:0]  dn;
   wire  [3:0]  dsv;
   wire  [3:0]  shc;
   wire  [3:0]  stc;

   int n_chk;
   int n_err;
   int cycle_n;

   hc595_chain_driver #(.DATA_W(16), .CLK_DIV(2), .MSB_FIRST(1'b1)) u_a (
      .clk_50mhz(clk), .rst(rst), .start(st[0]), .auto_en(au[0]), .data(dat[0][15:0]),
      .ready(rdy[0]), .done(dn[0]), .ds(dsv[0]), .sh_clk(shc[0]), .st_clk(stc[0]));
   hc595_chain_driver #(.DATA_W(16), .CLK_DIV(2), .MSB_FIRST(1'b0)) u_b (
      .clk_50mhz(clk), .rst(rst), .start(st[1]), .auto_en(au[1]), .data(dat[1][15:0]),
      .ready(rdy[1]), .done(dn[1]), .ds(dsv[1]), .sh_clk(shc[1]), .st_clk(stc[1]));
   hc595_chain_driver #(.DATA_W(24), .CLK_DIV(1), .MSB_FIRST(1'b1)) u_c (
      .clk_50mhz(clk), .rst(rst), .start(st[2]), .auto_en(au[2]), .data(dat[2][23:0]),
      .ready(rdy[2]), .done(dn[2]), .ds(dsv[2]), .sh_clk(shc[2]), .st_clk(stc[2]));
   hc595_chain_driver #(.DATA_W(8), .CLK_DIV(3), .MSB_FIRST(1'b1)) u_d (
      .clk_50mhz(clk), .rst(rst), .start(st[3]), .auto_en(au[3]), .data(dat[3][7:0]),
      .ready(rdy[3]), .done(dn[3]), .ds(dsv[3]), .sh_clk(shc[3]), .st_clk(stc[3]));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic int pd(input int i);
      case (i)
         0, 1:    return 16;
         2:       return 24;
         default: return 8;
      endcase
   endfunction

   function automatic int pc(input int i);
      case (i)
         0, 1:    return 2;
         2:       return 1;
         default: return 3;
      endcase
   endfunction

   function automatic logic [31:0] pmask(input int i);
      return (32'h1 << pd(i)) - 32'h1;
   endfunction

   // k-th bit put on the wire (k = 0 is the first one shifted out)
   function automatic logic mbit(input int i, input logic [31:0] w, input int k);
      if (i == 1) return w[k];
      else        return w[pd(i) - 1 - k];
   endfunction

   // ---------------- reference model ----------------
   logic        m_busy [4];
   int          m_t    [4];
   logic [31:0] m_word [4];
   logic        m_ds   [4];
   logic        m_done [4];

   task automatic model_step(input int i);
      int d;
      int c;
      d = pd(i);
      c = pc(i);
      m_done[i] = 1'b0;
      if (rst) begin
         m_busy[i] = 1'b0;
         m_t[i]    = 0;
         m_ds[i]   = 1'b0;
      end else if (!m_busy[i]) begin
         if (st[i] || au[i]) begin
            m_busy[i] = 1'b1;
            m_t[i]    = 0;
            m_word[i] = {8'h00, dat[i]} & pmask(i);
            m_ds[i]   = mbit(i, m_word[i], 0);
         end
      end else begin
         m_t[i] = m_t[i] + 1;
         if (m_t[i] == (2 * d + 1) * c) begin
            m_busy[i] = 1'b0;
            m_done[i] = 1'b1;
         end else if (m_t[i] < 2 * d * c) begin
            m_ds[i] = mbit(i, m_word[i], m_t[i] / (2 * c));
         end
      end
   endtask

   task automatic chk(input string nm, input int i, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s inst%0d cycle %0d: got %h expected %h", nm, i, cycle_n, act, exp);
      end
   endtask

   task automatic check_outputs(input int i);
      int  d;
      int  c;
      logic e_sh;
      logic e_st;
      d = pd(i);
      c = pc(i);
      e_sh = m_busy[i] && (m_t[i] < 2 * d * c) && (((m_t[i] / c) % 2) == 1);
      e_st = m_busy[i] && (m_t[i] >= 2 * d * c);
      chk("ready",  i, {31'b0, rdy[i]}, {31'b0, !m_busy[i]});
      chk("done",   i, {31'b0, dn[i]},  {31'b0, m_done[i]});
      chk("ds",     i, {31'b0, dsv[i]}, {31'b0, m_ds[i]});
      chk("sh_clk", i, {31'b0, shc[i]}, {31'b0, e_sh});
      chk("st_clk", i, {31'b0, stc[i]}, {31'b0, e_st});
   endtask

   // ---------------- observation ----------------
   logic [23:0] cap      [4];
   int          n_rise   [4];
   int          n_strise [4];
   int          n_done   [4];
   logic        prev_sh  [4];
   logic        prev_st  [4];

   task automatic clear_obs(input int i);
      cap[i]      = '0;
      n_rise[i]   = 0;
      n_strise[i] = 0;
      n_done[i]   = 0;
   endtask

   // One clock: model advances on the rising edge, DUT is compared on the
   // falling edge. Inputs are changed by the caller after this returns.
   task automatic cyc();
      @(posedge clk);
      for (int i = 0; i < 4; i++) model_step(i);
      @(negedge clk);
      cycle_n++;
      for (int i = 0; i < 4; i++) begin
         check_outputs(i);
         if (shc[i] === 1'b1 && prev_sh[i] === 1'b0) begin
            cap[i]    = {cap[i][22:0], dsv[i]};
            n_rise[i] = n_rise[i] + 1;
         end
         if (stc[i] === 1'b1 && prev_st[i] === 1'b0) n_strise[i] = n_strise[i] + 1;
         if (dn[i] === 1'b1) n_done[i] = n_done[i] + 1;
         prev_sh[i] = shc[i];
         prev_st[i] = stc[i];
      end
   endtask

   // ---------------- directed vectors ----------------
   typedef struct {
      int          inst;
      logic [23:0] data;
      logic        both;      // assert auto_en together with start
      logic        poke;      // re-assert start with new data at cycle 10
      logic [23:0] exp_word;  // bits in the order sampled at sh_clk rises
      int          exp_done;  // cycle of done relative to the accept edge
   } vec_t;

   vec_t vecs [8];

   task automatic run_frame(input vec_t v);
      int i;
      int n;
      int done_at;
      i = v.inst;
      clear_obs(i);
      dat[i] = v.data;
      st[i]  = 1'b1;
      au[i]  = v.both;
      cyc();
      st[i] = 1'b0;
      au[i] = 1'b0;
      n = 0;
      done_at = -1;
      while (n < 400) begin
         if (v.poke && n == 9) begin
            st[i]  = 1'b1;
            dat[i] = 24'hFFFFFF;
         end
         if (v.poke && n == 10) st[i] = 1'b0;
         cyc();
         n++;
         if (dn[i] === 1'b1 && done_at < 0) done_at = n;
         if (done_at >= 0 && n >= done_at + 5) break;
      end
      chk("done_cycle", i, done_at, v.exp_done);
      chk("word",       i, {8'h00, cap[i]} & pmask(i), {8'h00, v.exp_word});
      chk("done_count", i, n_done[i], 1);
      chk("sh_rises",   i, n_rise[i], pd(i));
      chk("st_rises",   i, n_strise[i], 1);
   endtask

   int          base;
   int          nd;
   int          dt [4];

   initial begin
      n_chk   = 0;
      n_err   = 0;
      cycle_n = 0;
      rst     = 1'b1;
      st      = '0;
      au      = '0;
      for (int i = 0; i < 4; i++) begin
         dat[i]     = '0;
         m_busy[i]  = 1'b0;
         m_t[i]     = 0;
         m_word[i]  = '0;
         m_ds[i]    = 1'b0;
         m_done[i]  = 1'b0;
         prev_sh[i] = 1'b0;
         prev_st[i] = 1'b0;
         clear_obs(i);
      end

      vecs[0] = '{0, 24'h00A5C3, 1'b0, 1'b0, 24'h00A5C3, 66};
      vecs[1] = '{1, 24'h00A5C3, 1'b0, 1'b0, 24'h00C3A5, 66};
      vecs[2] = '{0, 24'h00A5C3, 1'b0, 1'b1, 24'h00A5C3, 66};
      vecs[3] = '{3, 24'h000080, 1'b1, 1'b0, 24'h000080, 51};
      vecs[4] = '{2, 24'h123456, 1'b0, 1'b0, 24'h123456, 49};
      vecs[5] = '{1, 24'h000001, 1'b0, 1'b0, 24'h008000, 66};
      vecs[6] = '{3, 24'h000001, 1'b0, 1'b0, 24'h000001, 51};
      vecs[7] = '{0, 24'h00FFFF, 1'b0, 1'b0, 24'h00FFFF, 66};

      repeat (3) cyc();
      rst = 1'b0;
      cyc();

      for (int k = 0; k < 8; k++) run_frame(vecs[k]);

      // Reset in the middle of a frame aborts it without latching.
      clear_obs(0);
      dat[0] = 24'h00A5C3;
      st[0]  = 1'b1;
      cyc();
      st[0] = 1'b0;
      repeat (29) cyc();
      rst = 1'b1;
      cyc();
      rst = 1'b0;
      chk("abort_ready",  0, {31'b0, rdy[0]}, 32'd1);
      chk("abort_sh_clk", 0, {31'b0, shc[0]}, 32'd0);
      chk("abort_ds",     0, {31'b0, dsv[0]}, 32'd0);
      chk("abort_st_clk", 0, {31'b0, stc[0]}, 32'd0);
      chk("abort_done",   0, {31'b0, dn[0]},  32'd0);
      repeat (80) cyc();
      chk("abort_no_latch", 0, n_strise[0], 0);
      chk("abort_no_done",  0, n_done[0], 0);
      run_frame('{0, 24'h000001, 1'b0, 1'b0, 24'h000001, 66});

      // Free-running refresh on the 24-bit chain.
      clear_obs(2);
      dat[2] = 24'h123456;
      au[2]  = 1'b1;
      base   = cycle_n;
      nd     = 0;
      for (int k = 0; k < 4; k++) dt[k] = 0;
      for (int k = 0; k < 170; k++) begin
         cyc();
         if (dn[2] === 1'b1) begin
            if (nd < 4) dt[nd] = cycle_n;
            chk("auto_word", 2, {8'h00, cap[2]}, 32'h00123456);
            cap[2] = '0;
            nd++;
         end
      end
      chk("auto_frames",  2, nd, 3);
      chk("auto_first",   2, dt[0] - base, 50);
      chk("auto_period1", 2, dt[1] - dt[0], 50);
      chk("auto_period2", 2, dt[2] - dt[1], 50);
      au[2] = 1'b0;
      nd = 0;
      for (int k = 0; k < 80; k++) begin
         cyc();
         if (dn[2] === 1'b1) begin
            chk("auto_tail_word", 2, {8'h00, cap[2]}, 32'h00123456);
            nd++;
         end
      end
      chk("auto_tail_frames", 2, nd, 1);
      chk("auto_tail_ready",  2, {31'b0, rdy[2]}, 32'd1);

      // Random traffic on all instances, checked by the model every cycle.
      for (int k = 0; k < 4000; k++) begin
         rst = (($urandom % 500) == 0);
         for (int i = 0; i < 4; i++) begin
            st[i]  = (($urandom % 6) == 0);
            if (($urandom % 60) == 0) au[i] = ~au[i];
            dat[i] = 24'($urandom);
         end
         cyc();
      end
      rst = 1'b0;
      st  = '0;
      au  = '0;
      repeat (250) cyc();
      for (int i = 0; i < 4; i++) chk("final_ready", i, {31'b0, rdy[i]}, 32'd1);

      $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/hc595_chain_driver.md
Name: hc595_chain_driver

Overview:
- Parametrised serial driver for a chain of one or more cascaded 74HC595 shift registers. Typical loads are digit select plus segment data, or LED banks.
- Accepts a DATA_W-bit parallel word through a start/ready handshake and shifts it out on ds/sh_clk at a programmable rate. It then pulses st_clk to latch the 595 outputs and signals completion.
- Adds three things to the existing fixed 16-bit driver: configurable chain width, configurable shift rate, and selectable bit order. It also provides an optional free-running refresh mode.
- Sits between the display/LED controllers and the 595 pins.

Parameters:
DATA_W, 16, total bits shifted per frame (8 per chained 595); must be >= 1
CLK_DIV, 2, clk_50mhz cycles per half-period of sh_clk; must be >= 1 (2 gives 12.5 MHz sh_clk)
MSB_FIRST, 1, 1 = data[DATA_W-1] shifted first; 0 = data[0] shifted first

Ports:
clk_50mhz  input  1  system clock; the only clock in the block
rst  input  1  synchronous, active-high reset
start  input  1  request one frame; sampled only while ready=1
auto_en  input  1  level; while high, a new frame starts automatically whenever idle
data  input  DATA_W  parallel word; captured on the accept cycle only
ready  output  1  high in IDLE; a frame is accepted on a cycle where ready & (start | auto_en)
done  output  1  single-cycle pulse when the frame is latched
ds  output  1  serial data to the first 595 in the chain
sh_clk  output  1  shift clock; 595 samples ds on its rising edge
st_clk  output  1  storage (latch) clock; rising edge updates the 595 outputs

Behaviour:
- Reset (synchronous, rst=1 at a clk_50mhz edge): state=IDLE; ready=1; done=0; ds=0; sh_clk=0; st_clk=0; all counters cleared.
  - Reset mid-frame aborts immediately. No st_clk pulse is produced and no done pulse is produced.
- Everything is registered on clk_50mhz; no derived clocks. sh_clk and st_clk are register outputs.
- Internal tick: div_cnt counts 0..CLK_DIV-1 while in SHIFT or LATCH. A tick occurs when div_cnt == CLK_DIV-1. div_cnt is cleared on accept and on each state change.
- States:
  - IDLE:
    - If start | auto_en: accept. shreg <= data; ds <= first bit (per MSB_FIRST); sh_clk <= 0; bit_cnt <= 0; phase <= 0; ready <= 0; go to SHIFT.
    - start and auto_en high together yield exactly one accept.
  - SHIFT, phase 0 tick: sh_clk <= 1; phase <= 1.
  - SHIFT, phase 1 tick:
    - sh_clk <= 0 on every phase 1 tick.
    - If bit_cnt == DATA_W-1: st_clk <= 1; go to LATCH.
    - Else: bit_cnt++; ds <= next bit; phase <= 0.
  - LATCH tick: st_clk <= 0; done <= 1 for one cycle; ready <= 1; go to IDLE.
- ds changes only on sh_clk falling edges, or at accept. This gives ds CLK_DIV cycles of setup and hold around each sh_clk rise.
- Timing, with accept edge = cycle 0:
  - sh_clk rise k (k = 0..DATA_W-1) occurs at (2k+1)*CLK_DIV.
  - st_clk is high from cycle 2*DATA_W*CLK_DIV to (2*DATA_W+1)*CLK_DIV.
  - done and ready rise at (2*DATA_W+1)*CLK_DIV.
- Back-to-back frames: the earliest next accept is the cycle after done, because IDLE is visited for at least one cycle. Frame period in auto mode is therefore (2*DATA_W+1)*CLK_DIV + 1 cycles.
- start while ready=0 is ignored, not queued. Changes to data after accept do not affect the frame in flight.
- auto_en deasserted mid-frame: the current frame completes normally and no further frame starts.
- bit_cnt width is clog2(DATA_W) (minimum 1). div_cnt width is clog2(CLK_DIV) (minimum 1). No overflow is possible.

Test Plan:
1. DATA_W=16, CLK_DIV=2, MSB_FIRST=1; data=16'hA5C3, one-cycle start -> ds sampled at the 16 sh_clk rises = 1010_0101_1100_0011. sh_clk rises at cycles 2,6,...,62. st_clk is high for cycles 64-65. done is a single pulse at cycle 66, with ready=1 from the same cycle.
2. Same stimulus with MSB_FIRST=0 -> sampled bits = 1100_0011_1010_0101 (data[0] first). Timing is identical to scenario 1.
3. During the scenario-1 frame, assert start again at cycle 10 and change data to 16'hFFFF -> no effect on the frame. Exactly one done pulse; the sampled word is still 16'hA5C3.
4. rst=1 for one cycle at cycle 30 (mid-frame) -> next edge: ds=sh_clk=st_clk=0, ready=1, done=0. No st_clk rise ever occurs for the aborted frame. A subsequent start with data=16'h0001 completes correctly.
5. DATA_W=24, CLK_DIV=1, auto_en held high with data=24'h123456 -> consecutive frames each 50 cycles apart (49+1). Every frame shifts 24'h123456. Dropping auto_en mid-frame -> that frame finishes and ready stays 1 afterwards.
6. DATA_W=8, CLK_DIV=3; start and auto_en asserted together for one cycle, data=8'h80 -> exactly one frame. The first sampled bit is 1 and the rest are 0. done occurs at cycle 51.
